// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall encodings, divider states and HI/LO funct codes
package ex_stage_pkg;
    localparam int ID_TO_EX_WD  = 164;
    localparam int EX_TO_MEM_WD = 76;
    localparam int STALL_WD     = 6;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/ex_stage_div.sv
// div_iter: 32-step restoring divider on magnitudes with sign fix-up at the end
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic        abort,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);
    div_state_e  state, state_nx;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] dvs;
    logic        neg_q, neg_r, by_zero;
    logic [33:0] diff;

    // 33-bit partial remainder keeps the bit shifted out of a large unsigned remainder
    assign diff = {1'b0, acc[63:31]} - {2'b0, dvs};
    assign quo  = by_zero ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
    assign rem  = neg_r ? -acc[63:32] : acc[63:32];

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= DIV_IDLE;
        else     state <= state_nx;

    // next state and status flags; abort wins from any state
    always_comb begin
        busy     = state == DIV_BUSY;
        done     = state == DIV_DONE;
        state_nx = abort                               ? DIV_IDLE :
                   (state == DIV_IDLE && start)        ? DIV_BUSY :
                   (state == DIV_BUSY && cnt == 5'd31) ? DIV_DONE :
                   (state == DIV_DONE)                 ? DIV_IDLE : state;
    end

    // operand latch on start, then one restoring step per busy cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            by_zero <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            acc     <= {32'b0, mag(opa, signed_op)};
            dvs     <= mag(opb, signed_op);
            cnt     <= '0;
            neg_q   <= signed_op & (opa[31] ^ opb[31]);
            neg_r   <= signed_op & opa[31];
            by_zero <= opb == '0;
        end else if (state == DIV_BUSY) begin
            acc <= diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
            cnt <= cnt + 5'd1;
        end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ALU, HI/LO with mult and iterative divide, data SRAM request
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    ex_we,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_ram_read,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);
    logic [ID_TO_EX_WD-1:0] ex_bus;
    logic [4:0]  mem_op, rf_waddr;
    logic [31:0] pc, inst, rs_val, rt_val, src1, src2, alu_res, sra_res, ex_result, hi, lo, quo, rem;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res, special, div_busy, div_done, unused_ok;
    logic        is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, commit;
    logic [63:0] prod;

    // EX register: flush, then bubble insertion, then load, otherwise hold
    always_ff @(posedge clk or posedge rst)
        if (rst)                                      ex_bus <= '0;
        else if (flush)                               ex_bus <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP) ex_bus <= '0;
        else if (stall[2] == NO_STOP)                 ex_bus <= id_to_ex_bus;

    assign {mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = ex_bus;

    assign src1 = ({32{sel_src1[0]}} & rs_val)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rt_val)
                | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});
    assign sra_res = $signed(src2) >>> src1[4:0];

    assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                   | ({32{alu_op[10]}} & (src1 - src2))
                   | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                   | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

    assign special  = inst[31:26] == 6'd0;
    assign is_mult  = special && inst[5:0] == F_MULT;
    assign is_multu = special && inst[5:0] == F_MULTU;
    assign is_div   = special && inst[5:0] == F_DIV;
    assign is_divu  = special && inst[5:0] == F_DIVU;
    assign is_mfhi  = special && inst[5:0] == F_MFHI;
    assign is_mflo  = special && inst[5:0] == F_MFLO;
    assign is_mthi  = special && inst[5:0] == F_MTHI;
    assign is_mtlo  = special && inst[5:0] == F_MTLO;

    assign prod = is_mult ? {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val}
                          : {32'b0, rs_val} * {32'b0, rt_val};

    div_iter u_div (
        .clk(clk), .rst(rst), .start(is_div | is_divu), .signed_op(is_div), .abort(flush),
        .opa(rs_val), .opb(rt_val), .busy(div_busy), .done(div_done), .quo(quo), .rem(rem)
    );

    // a flushed instruction never commits to HI/LO
    assign commit = stall[3] == NO_STOP && !flush;

    // HI/LO writes from mult, mthi/mtlo and a finished divide
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (is_mult || is_multu)                    {hi, lo} <= prod;
            else if (is_mthi)                           hi <= rs_val;
            else if (is_mtlo)                           lo <= rs_val;
            else if ((is_div || is_divu) && div_done)   {hi, lo} <= {rem, quo};
        end

    assign ex_result       = is_mfhi ? hi : is_mflo ? lo : alu_res;
    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_we           = rf_we;
    assign ex_waddr        = rf_waddr;
    assign ex_wdata        = ex_result;
    assign ex_ram_read     = ram_en && ram_wen == 4'd0;
    assign stallreq_for_ex = (is_div || is_divu) && !div_done;
    assign data_sram_en    = ram_en && stall[3] == NO_STOP;
    assign data_sram_wen   = ram_wen != 4'd0 ? 4'hF : 4'h0;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rt_val;
    assign unused_ok       = ^{mem_op, inst[25:16], stall[5:4], stall[1:0], div_busy};
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage. Registers the decode-to-execute bus and evaluates the one-hot ALU operation. Owns the HI/LO registers and an iterative 32-cycle divider, and issues the data-SRAM request. Returns forwarding/load-use information to decode and produces the execute-to-memory bus.

## Interface
- `ID_TO_EX_WD`, 164, decode-to-execute bus width: mem_op[163:159], pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_val[63:32], rt_val[31:0].
- `EX_TO_MEM_WD`, 76, execute-to-memory bus width: pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- `StallBus`, 6, stall vector width.
- clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  clears the EX register and aborts any divide.
- stall  in  StallBus  stall vector; bit 2 = ID/EX source, bit 3 = EX hold.
- id_to_ex_bus  in  ID_TO_EX_WD  decoded instruction from decode.
- ex_to_mem_bus  out  EX_TO_MEM_WD  result bundle to the memory stage.
- ex_we, ex_waddr[4:0], ex_wdata[31:0]  out  forwarding tap to decode.
- ex_ram_read  out  1  current instruction is a load.
- stallreq_for_ex  out  1  divider is occupying EX.
- data_sram_en  out  1  data SRAM enable.
- data_sram_wen  out  4  data SRAM byte write enables.
- data_sram_addr  out  32  data SRAM address.
- data_sram_wdata  out  32  data SRAM write data.

## Operation
- EX register update, in priority order:
  - rst (async): clear EX register, HI, LO, divider FSM.
  - flush: clear.
  - stall[2]=Stop and stall[3]=NoStop: clear (insert bubble).
  - stall[2]=NoStop: load id_to_ex_bus.
  - otherwise: hold.
- src1 is one-hot: [0] rs_val, [1] pc, [2] {27'b0, inst[10:6]}.
- src2 is one-hot: [0] rt_val, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0].
- alu_op bits, MSB to LSB: add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts are src2 by src1[4:0].
  - lui yields {src2[15:0], 16'b0}.
  - All-zero alu_op yields 0.
- HI/LO ops are decoded here from inst (opcode 0, funct): mult 18, multu 19, div 1A, divu 1B, mfhi 10, mflo 12, mthi 11, mtlo 13.
  - mult/multu: combinational 64-bit product; {HI,LO} written at the clock edge ending the cycle, provided stall[3]=NoStop.
  - mthi/mtlo write rs_val.
  - mfhi/mflo: ex_result is HI/LO, overriding the ALU result.
- Divider FSM has states IDLE, BUSY, DONE.
  - IDLE→BUSY when a div/divu is present: latch the magnitudes (signed) or raw operands (unsigned); counter=0.
  - BUSY: one restoring step per cycle; after 32 steps →DONE.
  - DONE: apply signs (quotient sign rs[31]^rt[31], remainder sign rs[31]). Write LO=quotient, HI=remainder when stall[3]=NoStop, then →IDLE.
  - Divide by zero: LO=32'hFFFF_FFFF, HI=rs_val, same latency.
- stallreq_for_ex = div/divu present and FSM ≠ DONE.
- Memory request:
  - data_sram_en = data_ram_en.
  - data_sram_wen = 4'b1111 if data_ram_wen≠0, else 0.
  - data_sram_addr = ALU result; data_sram_wdata = rt_val.
  - The request is suppressed (en=0) while stall[3]=Stop.
- Forwarding tap:
  - ex_we = rf_we; ex_waddr = rf_waddr; ex_wdata = ex_result.
  - ex_ram_read = data_ram_en & (data_ram_wen==0).

## Timing
- ALU, mult, mf*, forwarding and SRAM request: combinational from the EX register; the result is on ex_to_mem_bus in the same cycle.
- Divide: stallreq_for_ex high for 33 consecutive cycles (1 IDLE + 32 BUSY), low in DONE. HI/LO are visible to the next instruction in EX.
- Back-to-back divides: the second starts in IDLE in the cycle after DONE.
- flush or rst during BUSY: FSM→IDLE immediately, HI/LO unchanged, stallreq deasserts next cycle.
- Reset values: every output is 0, including ex_to_mem_bus and all data_sram_* signals.
- Writes to register 0 are still forwarded; decode handles r0.

## Structure
- `lib/defines.vh` holds: ID_TO_EX_WD, EX_TO_MEM_WD, StallBus, Stop/NoStop, and the divider state encodings DivIdle/DivBusy/DivDone.
- Sub-module `div_iter`: FSM, counter, 64-bit partial remainder, sign fix-up. Ports: start, signed_op, abort, opa, opb, busy, done, quo, rem.

## Test plan
- ALU: addiu, rs=0x7FFF_FFFF, imm=0x0001 → ex_wdata=0x8000_0000, ex_we=1. sltu 1 vs 0xFFFF_FFFF → 1.
- Load: lw with rs=0x1000, imm=0xFFFC → data_sram_addr=0x0FFC, data_sram_en=1, data_sram_wen=0, ex_ram_read=1.
- mult −3×7, then mflo/mfhi in consecutive cycles → 0xFFFF_FFEB, then 0xFFFF_FFFF.
- div −7/2 → stallreq high exactly 33 cycles; then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. divu x/0 → LO=0xFFFF_FFFF, HI=x.
- flush at BUSY cycle 10 → stallreq low next cycle; HI/LO retain their prior values; a following divu completes normally.
- stall[2]=Stop, stall[3]=NoStop → bubble with an all-zero bus. Async rst mid-cycle → outputs 0 with no clock edge.
